// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: status/RX/TX registers, TX/RX FIFOs and the TX handshake FSM.
// Optional build macro UART_RX_OVERRUN_EN: always-ready RX with sticky overrun flag instead of back-pressure.
module uart_mmio_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic        WE,
    input  logic        RE,
    output logic [31:0] RData,
    output logic [7:0]  DataIn,
    output logic        DataInValid,
    input  logic        DataInReady,
    input  logic [7:0]  DataOut,
    input  logic        DataOutValid,
    output logic        DataOutReady
);
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;

    localparam logic [31:0] ADDR_STAT = 32'h8000_0000;
    localparam logic [31:0] ADDR_RX   = 32'h8000_0004;
    localparam logic [31:0] ADDR_TX   = 32'h8000_0008;

    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
    localparam logic [TX_CW-1:0] TX_CNT_ONE  = TX_CW'(1);
    localparam logic [TX_PW-1:0] TX_PTR_ONE  = TX_PW'(1);
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
    localparam logic [RX_CW-1:0] RX_CNT_ONE  = RX_CW'(1);
    localparam logic [RX_PW-1:0] RX_PTR_ONE  = RX_PW'(1);

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    logic             sel_stat_s, sel_rx_s, sel_tx_s;
    logic [7:0]       tx_mem_r [TX_DEPTH];
    logic [TX_PW-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [TX_CW-1:0] tx_cnt_r;
    logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic [7:0]       rx_mem_r [RX_DEPTH];
    logic [RX_PW-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [RX_CW-1:0] rx_cnt_r;
    logic             rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    tx_state_t        tx_state_r, tx_state_s;
    logic [7:0]       hold_r;
    logic             ovr_s;
    logic             unused_s;

    assign sel_stat_s = (Addr == ADDR_STAT);
    assign sel_rx_s   = (Addr == ADDR_RX);
    assign sel_tx_s   = (Addr == ADDR_TX);
    assign tx_full_s  = (tx_cnt_r == TX_FULL_CNT);
    assign tx_empty_s = (tx_cnt_r == {TX_CW{1'b0}});
    assign rx_full_s  = (rx_cnt_r == RX_FULL_CNT);
    assign rx_empty_s = (rx_cnt_r == {RX_CW{1'b0}});
    assign unused_s   = ^WData[31:8];

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign tx_push_s  = WE && sel_tx_s && (!tx_full_s || tx_pop_s);
    assign rx_pop_s   = RE && sel_rx_s && !rx_empty_s;

    assign DataIn      = hold_r;
    assign DataInValid = (tx_state_r == TX_SEND);

`ifdef UART_RX_OVERRUN_EN
    logic ovr_r;
    logic ovr_set_s;

    assign DataOutReady = 1'b1;
    assign rx_push_s    = DataOutValid && (!rx_full_s || rx_pop_s);
    assign ovr_set_s    = DataOutValid && rx_full_s && !rx_pop_s;
    assign ovr_s        = ovr_r;

    // Sticky overrun flag; a fresh overrun beats the clearing status read.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ovr_r <= 1'b0;
        end else if (ovr_set_s) begin
            ovr_r <= 1'b1;
        end else if (RE && sel_stat_s) begin
            ovr_r <= 1'b0;
        end
    end
`else
    assign DataOutReady = !rx_full_s;
    assign rx_push_s    = DataOutValid && DataOutReady;
    assign ovr_s        = 1'b0;
`endif

    // TX FIFO storage.
    always_ff @(posedge Clock) begin
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= WData[7:0];
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tx_wr_ptr_r <= {TX_PW{1'b0}};
            tx_rd_ptr_r <= {TX_PW{1'b0}};
            tx_cnt_r    <= {TX_CW{1'b0}};
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_PTR_ONE;
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_PTR_ONE;
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_cnt_r <= tx_cnt_r + TX_CNT_ONE;
                2'b01:   tx_cnt_r <= tx_cnt_r - TX_CNT_ONE;
                default: tx_cnt_r <= tx_cnt_r;
            endcase
        end
    end

    // RX FIFO storage.
    always_ff @(posedge Clock) begin
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= DataOut;
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_wr_ptr_r <= {RX_PW{1'b0}};
            rx_rd_ptr_r <= {RX_PW{1'b0}};
            rx_cnt_r    <= {RX_CW{1'b0}};
        end else begin
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_PTR_ONE;
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR_ONE;
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_cnt_r <= rx_cnt_r + RX_CNT_ONE;
                2'b01:   rx_cnt_r <= rx_cnt_r - RX_CNT_ONE;
                default: rx_cnt_r <= rx_cnt_r;
            endcase
        end
    end

    // TX FSM state and the hold register that keeps DataIn stable during SEND.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tx_state_r <= TX_IDLE;
            hold_r     <= 8'h00;
        end else begin
            tx_state_r <= tx_state_s;
            if (tx_pop_s) hold_r <= tx_mem_r[tx_rd_ptr_r];
        end
    end

    // TX FSM next state and FIFO pop.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_state_s = TX_SEND;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (DataInReady) begin
                    tx_state_s = TX_IDLE;
                end else begin
                    tx_state_s = TX_SEND;
                end
            end
            default: tx_state_s = TX_IDLE;
        endcase
    end

    // Load data decode; unmapped or write-only addresses read as zero.
    always_comb begin
        RData = 32'h0000_0000;
        if (sel_stat_s) begin
            RData = {29'h0000_0000, ovr_s, !rx_empty_s, !tx_full_s};
        end else if (sel_rx_s && !rx_empty_s) begin
            RData = {24'h00_0000, rx_mem_r[rx_rd_ptr_r]};
        end else begin
            RData = 32'h0000_0000;
        end
    end
endmodule
